// File: rtl/cdb_arbiter.sv
// Common Data Bus transmitter: per-source result FIFOs, round-robin pop, registered broadcast.
// Optional feature: define CDB_FLUSH_EN to add a synchronous flush input that squashes all pending results.
module cdb_arbiter #(
   parameter int N_SRC      = 3,
   parameter int TAG_W      = 7,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                      clock,
   input  logic                      resetn,
`ifdef CDB_FLUSH_EN
   input  logic                      flush,
`endif
   input  logic [N_SRC-1:0]          src_valid,
   input  logic [N_SRC*TAG_W-1:0]    src_tag,
   input  logic [N_SRC*DATA_W-1:0]   src_result,
   output logic [N_SRC-1:0]          src_ready,
   output logic                      cdb_control,
   output logic [TAG_W-1:0]          cdb_dest_tag,
   output logic [DATA_W-1:0]         cdb_result
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int RR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int ENT_W = TAG_W + DATA_W;

   logic [ENT_W-1:0] mem [N_SRC][FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr [N_SRC];
   logic [PTR_W:0]   rd_ptr [N_SRC];
   logic [N_SRC-1:0] full;
   logic [N_SRC-1:0] empty;
   logic [N_SRC-1:0] push;
   logic [N_SRC-1:0] pop;
   logic [RR_W-1:0]  rr_ptr;
   logic [RR_W-1:0]  rr_next;
   logic [RR_W-1:0]  grant_idx;
   logic             grant_valid;
   logic             flush_i;
   logic [ENT_W-1:0] head_entry;

`ifdef CDB_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   function automatic logic [RR_W-1:0] wrap_idx(input int a);
      return RR_W'(a % N_SRC);
   endfunction

   // Occupancy flags; the extra pointer MSB separates full from empty at wrap-around.
   always_comb begin
      full      = '0;
      empty     = '0;
      src_ready = '0;
      push      = '0;
      for (int i = 0; i < N_SRC; i++) begin
         empty[i]     = (wr_ptr[i] == rd_ptr[i]);
         full[i]      = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                        (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
         src_ready[i] = !full[i] && !flush_i;
         push[i]      = src_valid[i] && src_ready[i];
      end
   end

   // Rotating search starting at rr_ptr; the first non-empty FIFO wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      rr_next     = rr_ptr;
      for (int k = 0; k < N_SRC; k++) begin
         if (!grant_valid && !empty[wrap_idx(int'(rr_ptr) + k)]) begin
            grant_valid = 1'b1;
            grant_idx   = wrap_idx(int'(rr_ptr) + k);
         end
      end
      if (flush_i) begin
         grant_valid = 1'b0;
      end
      if (grant_valid) begin
         rr_next = wrap_idx(int'(grant_idx) + 1);
      end
   end

   always_comb begin
      pop = '0;
      if (grant_valid) begin
         pop[grant_idx] = 1'b1;
      end
      head_entry = mem[grant_idx][rd_ptr[grant_idx][PTR_W-1:0]];
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < N_SRC; i++) begin
         if (push[i]) begin
            mem[i][wr_ptr[i][PTR_W-1:0]] <= {src_tag[i*TAG_W +: TAG_W],
                                             src_result[i*DATA_W +: DATA_W]};
         end
      end
   end

   // Pointer, arbitration and broadcast registers; tag/result only load on a pop.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < N_SRC; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
         rr_ptr       <= '0;
         cdb_control  <= 1'b0;
         cdb_dest_tag <= '0;
         cdb_result   <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < N_SRC; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
         rr_ptr      <= '0;
         cdb_control <= 1'b0;
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) begin
               wr_ptr[i] <= wr_ptr[i] + (PTR_W+1)'(1);
            end
            if (pop[i]) begin
               rd_ptr[i] <= rd_ptr[i] + (PTR_W+1)'(1);
            end
         end
         rr_ptr      <= rr_next;
         cdb_control <= grant_valid;
         if (grant_valid) begin
            {cdb_dest_tag, cdb_result} <= head_entry;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table plus hand sequences, backed by a queue-based reference scoreboard.
module tb_cdb_arbiter;

   typedef logic [38:0] ent_t;

   typedef struct {
      logic        rst_before;
      logic [2:0]  v;
      logic [20:0] tags;
      logic [95:0] res;
      logic        exp_ctl;
      logic [6:0]  exp_tag;
      logic [31:0] exp_res;
      logic [2:0]  exp_rdy;
   } vec_t;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        flush_b = 1'b0;
   logic [2:0]  src_valid = '0;
   logic [20:0] src_tag = '0;
   logic [95:0] src_result = '0;
   logic [2:0]  src_ready;
   logic        cdb_control;
   logic [6:0]  cdb_dest_tag;
   logic [31:0] cdb_result;

   int total = 0;
   int bad = 0;

   ent_t mq [3][$];
   ent_t exp_q [$];
   logic [6:0] seen [$];
   int   m_rr = 0;
   logic m_ctl = 1'b0;
   logic [6:0]  m_tag = '0;
   logic [31:0] m_res = '0;
   int   win;
   logic [2:0] mrdy;

   vec_t tbl [9];

   cdb_arbiter #(.N_SRC(3), .TAG_W(7), .DATA_W(32), .FIFO_DEPTH(2)) dut (
      .clock        (clock),
      .resetn       (resetn),
`ifdef CDB_FLUSH_EN
      .flush        (flush_b),
`endif
      .src_valid    (src_valid),
      .src_tag      (src_tag),
      .src_result   (src_result),
      .src_ready    (src_ready),
      .cdb_control  (cdb_control),
      .cdb_dest_tag (cdb_dest_tag),
      .cdb_result   (cdb_result)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1, "watchdog");
   end

   // Reference model: per-source queues, rotating search, one pop per edge.
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 3; i++) mq[i].delete();
         exp_q.delete();
         m_rr  = 0;
         m_ctl = 1'b0;
         m_tag = '0;
         m_res = '0;
      end else begin
         win = -1;
         for (int i = 0; i < 3; i++) mrdy[i] = (mq[i].size() < 2) && !flush_b;
         if (flush_b) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_rr  = 0;
            m_ctl = 1'b0;
         end else begin
            for (int k = 0; k < 3; k++) begin
               if (win < 0 && mq[(m_rr + k) % 3].size() > 0) win = (m_rr + k) % 3;
            end
            m_ctl = (win >= 0);
            if (win >= 0) begin
               exp_q.push_back(mq[win][0]);
               {m_tag, m_res} = mq[win][0];
               void'(mq[win].pop_front());
               m_rr = (win + 1) % 3;
            end
            for (int i = 0; i < 3; i++) begin
               if (src_valid[i] && mrdy[i]) mq[i].push_back({src_tag[i*7 +: 7], src_result[i*32 +: 32]});
            end
         end
      end
   end

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [2:0] model_ready();
      logic [2:0] r;
      for (int i = 0; i < 3; i++) r[i] = (mq[i].size() < 2) && !flush_b;
      return r;
   endfunction

   task automatic check_sb();
      ent_t e;
      cmp("sb_ctl", 64'(cdb_control), 64'(m_ctl));
      cmp("sb_ready", 64'(src_ready), 64'(model_ready()));
      cmp("sb_hold_tag", 64'(cdb_dest_tag), 64'(m_tag));
      cmp("sb_hold_res", 64'(cdb_result), 64'(m_res));
      if (cdb_control === 1'b1) begin
         seen.push_back(cdb_dest_tag);
         if (exp_q.size() == 0) begin
            cmp("sb_unexpected", 64'(cdb_dest_tag), 64'h0);
            cmp("sb_queue_empty", 64'd1, 64'(exp_q.size()));
         end else begin
            e = exp_q.pop_front();
            cmp("sb_tag", 64'(cdb_dest_tag), 64'(e[38:32]));
            cmp("sb_res", 64'(cdb_result), 64'(e[31:0]));
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      check_sb();
   endtask

   task automatic set_src(input int i, input logic v, input logic [6:0] t, input logic [31:0] r);
      src_valid[i] = v;
      src_tag[i*7 +: 7] = t;
      src_result[i*32 +: 32] = r;
   endtask

   task automatic do_reset();
      src_valid = '0;
      @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      seen.delete();
   endtask

   function automatic vec_t mk(input logic rb, input logic [2:0] v, input logic [20:0] t,
                               input logic [95:0] r, input logic ec, input logic [6:0] et,
                               input logic [31:0] er, input logic [2:0] erdy);
      vec_t x;
      x.rst_before = rb; x.v = v; x.tags = t; x.res = r;
      x.exp_ctl = ec; x.exp_tag = et; x.exp_res = er; x.exp_rdy = erdy;
      return x;
   endfunction

   initial begin
      int n [3];
      logic [2:0] acc;
      logic saw_full;
      logic [6:0] got1 [$];
      logic [6:0] exp3 [3];

      // single push, then round-robin from a fresh reset
      tbl[0] = mk(1'b1, 3'b001, {14'h0, 7'h05}, {64'h0, 32'hDEAD_BEEF}, 1'b0, 7'h00, 32'h0, 3'b111);
      tbl[1] = mk(1'b0, 3'b000, 21'h0, 96'h0, 1'b1, 7'h05, 32'hDEAD_BEEF, 3'b111);
      tbl[2] = mk(1'b0, 3'b000, 21'h0, 96'h0, 1'b0, 7'h05, 32'hDEAD_BEEF, 3'b111);
      tbl[3] = mk(1'b1, 3'b111, {7'd3, 7'd2, 7'd1}, {32'h1000_0003, 32'h1000_0002, 32'h1000_0001},
                  1'b0, 7'h00, 32'h0, 3'b111);
      tbl[4] = mk(1'b0, 3'b000, 21'h0, 96'h0, 1'b1, 7'd1, 32'h1000_0001, 3'b111);
      tbl[5] = mk(1'b0, 3'b000, 21'h0, 96'h0, 1'b1, 7'd2, 32'h1000_0002, 3'b111);
      tbl[6] = mk(1'b0, 3'b001, {14'h0, 7'd4}, {64'h0, 32'h1000_0004}, 1'b1, 7'd3, 32'h1000_0003, 3'b111);
      tbl[7] = mk(1'b0, 3'b000, 21'h0, 96'h0, 1'b1, 7'd4, 32'h1000_0004, 3'b111);
      tbl[8] = mk(1'b0, 3'b000, 21'h0, 96'h0, 1'b0, 7'd4, 32'h1000_0004, 3'b111);

      #12;
      resetn = 1'b1;
      #1;
      cmp("reset_ctl", 64'(cdb_control), 64'h0);
      cmp("reset_tag", 64'(cdb_dest_tag), 64'h0);
      cmp("reset_res", 64'(cdb_result), 64'h0);
      cmp("reset_ready", 64'(src_ready), 64'h7);

      for (int r = 0; r < 9; r++) begin
         if (tbl[r].rst_before) do_reset();
         src_valid  = tbl[r].v;
         src_tag    = tbl[r].tags;
         src_result = tbl[r].res;
         tick();
         cmp($sformatf("vec%0d_ctl", r), 64'(cdb_control), 64'(tbl[r].exp_ctl));
         cmp($sformatf("vec%0d_tag", r), 64'(cdb_dest_tag), 64'(tbl[r].exp_tag));
         cmp($sformatf("vec%0d_res", r), 64'(cdb_result), 64'(tbl[r].exp_res));
         cmp($sformatf("vec%0d_rdy", r), 64'(src_ready), 64'(tbl[r].exp_rdy));
      end

      // idle: no broadcasts, and the pointer (now at source 1) is kept
      src_valid = '0;
      seen.delete();
      repeat (10) tick();
      cmp("idle_none", 64'(seen.size()), 64'd0);
      set_src(0, 1'b1, 7'h11, 32'h2000_0011);
      set_src(1, 1'b1, 7'h12, 32'h2000_0012);
      set_src(2, 1'b1, 7'h13, 32'h2000_0013);
      tick();
      src_valid = '0;
      repeat (4) tick();
      exp3 = '{7'h12, 7'h13, 7'h11};
      cmp("idle_cnt", 64'(seen.size()), 64'd3);
      for (int j = 0; j < 3; j++) begin
         if (j < seen.size()) cmp($sformatf("idle_order%0d", j), 64'(seen[j]), 64'(exp3[j]));
      end

      // backpressure: source 1 delivers 4 results while 0 and 2 stream
      do_reset();
      n = '{0, 0, 0};
      saw_full = 1'b0;
      for (int c = 0; c < 60 && n[1] < 4; c++) begin
         set_src(0, 1'b1, 7'(32'h20 + n[0]), 32'(32'hB000_0000 + n[0]));
         set_src(1, n[1] < 4, 7'(32'h40 + n[1]), 32'(32'hB100_0000 + n[1]));
         set_src(2, 1'b1, 7'(32'h60 + n[2]), 32'(32'hB200_0000 + n[2]));
         if (src_ready[1] == 1'b0) saw_full = 1'b1;
         acc = src_valid & src_ready;
         tick();
         for (int i = 0; i < 3; i++) if (acc[i]) n[i]++;
      end
      cmp("bp_done", 64'(n[1]), 64'd4);
      cmp("bp_saw_full", 64'(saw_full), 64'd1);
      src_valid = '0;
      repeat (10) tick();
      foreach (seen[j]) if (seen[j][6:5] == 2'b10) got1.push_back(seen[j]);
      cmp("bp_cnt", 64'(got1.size()), 64'd4);
      for (int j = 0; j < 4; j++) begin
         if (j < got1.size()) cmp($sformatf("bp_order%0d", j), 64'(got1[j]), 64'(7'h40 + 7'(j)));
      end

      // reset asserted with entries pending
      n = '{0, 0, 0};
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 3; i++) set_src(i, 1'b1, 7'(32'h30 + 4*i + n[i]), 32'(32'hC000_0000 + n[i]));
         acc = src_valid & src_ready;
         tick();
         for (int i = 0; i < 3; i++) if (acc[i]) n[i]++;
      end
      #2;
      resetn = 1'b0;
      #1;
      cmp("rst_mid_ctl", 64'(cdb_control), 64'h0);
      cmp("rst_mid_tag", 64'(cdb_dest_tag), 64'h0);
      cmp("rst_mid_res", 64'(cdb_result), 64'h0);
      cmp("rst_mid_rdy", 64'(src_ready), 64'h7);
      src_valid = '0;
      @(negedge clock);
      resetn = 1'b1;
      seen.delete();
      repeat (4) tick();
      cmp("rst_no_stale", 64'(seen.size()), 64'd0);
      cmp("rst_rdy_after", 64'(src_ready), 64'h7);

`ifdef CDB_FLUSH_EN
      do_reset();
      set_src(0, 1'b1, 7'd10, 32'hF000_000A);
      set_src(1, 1'b1, 7'd11, 32'hF000_000B);
      set_src(2, 1'b1, 7'd12, 32'hF000_000C);
      tick();
      src_valid = '0;
      set_src(2, 1'b1, 7'd13, 32'hF000_000D);
      flush_b = 1'b1;
      #1;
      cmp("flush_rdy", 64'(src_ready), 64'h0);
      seen.delete();
      tick();
      flush_b = 1'b0;
      src_valid = '0;
      repeat (4) tick();
      cmp("flush_none", 64'(seen.size()), 64'd0);
      set_src(0, 1'b1, 7'd14, 32'hF000_000E);
      tick();
      src_valid = '0;
      tick();
      cmp("flush_after_ctl", 64'(cdb_control), 64'h1);
      cmp("flush_after_tag", 64'(cdb_dest_tag), 64'd14);
      tick();
      cmp("flush_after_idle", 64'(cdb_control), 64'h0);
`endif

      src_valid = '0;
      repeat (5) tick();
      cmp("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
